// File: rtl/arm_defs_pkg.sv
// Shared ARM-subset definitions: ALU command codes and NZCV bit positions.
package arm_defs_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/alu_unit.sv
// Combinational execute ALU; produces the result and the would-be NZCV value.
module alu_unit
  import arm_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       exe_cmd,
  input  logic             cin,
  input  logic [3:0]       nzcv_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv_next
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] wide;
  logic           upd_nz, upd_cv, c_new, v_new;

  always_comb begin
    wide      = '0;
    result    = '0;
    upd_nz    = 1'b1;
    upd_cv    = 1'b0;
    c_new     = 1'b0;
    v_new     = 1'b0;
    nzcv_next = nzcv_in;
    case (exe_cmd)
      CMD_MOV: result = b;
      CMD_MVN: result = ~b;
      CMD_AND: result = a & b;
      CMD_ORR: result = a | b;
      CMD_EOR: result = a ^ b;
      CMD_ADD, CMD_ADC: begin
        wide   = {1'b0, a} + {1'b0, b} +
                 {{WIDTH{1'b0}}, (exe_cmd == CMD_ADC) & cin};
        result = wide[MSB:0];
        upd_cv = 1'b1;
        c_new  = wide[WIDTH];
        v_new  = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        // Bit WIDTH of the extended difference is the borrow; C is its inverse.
        wide   = {1'b0, a} - {1'b0, b} -
                 {{WIDTH{1'b0}}, (exe_cmd == CMD_SBC) & ~cin};
        result = wide[MSB:0];
        upd_cv = 1'b1;
        c_new  = ~wide[WIDTH];
        v_new  = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      default: upd_nz = 1'b0;
    endcase
    if (upd_nz) begin
      nzcv_next[N_BIT] = result[MSB];
      nzcv_next[Z_BIT] = ~|result;
    end
    if (upd_cv) begin
      nzcv_next[C_BIT] = c_new;
      nzcv_next[V_BIT] = v_new;
    end
  end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: ID/EX register, ALU, NZCV status, branch target and EX/MEM register.
module exe_stage_unit
  import arm_defs_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_in,
  input  logic              stall_in,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [3:0]        exe_cmd,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              s,
  input  logic              b,
  input  logic              wb_en,
  input  logic [WIDTH-1:0]  val_rn,
  input  logic [WIDTH-1:0]  val2,
  input  logic [WIDTH-1:0]  val_rm,
  input  logic [REG_AW-1:0] dest,
  input  logic [23:0]       imm24,
  output logic              branch_taken,
  output logic [WIDTH-1:0]  branch_addr,
  output logic [3:0]        status,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_alu_res,
  output logic [WIDTH-1:0]  ex_st_val,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en
);

  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  val_rn;
    logic [WIDTH-1:0]  val2;
    logic [WIDTH-1:0]  val_rm;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              s;
    logic              b;
    logic              wb_en;
    logic [REG_AW-1:0] dest;
    logic [23:0]       imm24;
  } id_ex_t;

  localparam int STAGES = 1;

  // vld_pipe[0] = ID/EX valid, vld_pipe[1] = EX/MEM valid
  logic [STAGES:0]  vld_pipe;
  id_ex_t           idex, id_in;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       nzcv_next;
  logic             kill, status_upd;

  always_comb begin
    id_in          = '0;
    id_in.pc       = pc_in;
    id_in.val_rn   = val_rn;
    id_in.val2     = val2;
    id_in.val_rm   = val_rm;
    id_in.exe_cmd  = exe_cmd;
    id_in.mem_r_en = mem_r_en;
    id_in.mem_w_en = mem_w_en;
    id_in.s        = s;
    id_in.b        = b;
    id_in.wb_en    = wb_en;
    id_in.dest     = dest;
    id_in.imm24    = imm24;
  end

  alu_unit #(.WIDTH(WIDTH)) u_alu (
    .a         (idex.val_rn),
    .b         (idex.val2),
    .exe_cmd   (idex.exe_cmd),
    .cin       (status[C_BIT]),
    .nzcv_in   (status),
    .result    (alu_res),
    .nzcv_next (nzcv_next)
  );

  assign branch_taken = vld_pipe[0] & idex.b;
  assign branch_addr  = idex.pc + ({{(WIDTH-24){idex.imm24[23]}}, idex.imm24} << 2);
  assign status_upd   = vld_pipe[0] & idex.s & ~idex.mem_r_en & ~idex.mem_w_en;
  // A taken branch squashes the instruction behind it.
  assign kill         = flush_in | stall_in | branch_taken;
  assign ex_valid     = vld_pipe[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      idex        <= '0;
      status      <= '0;
      ex_alu_res  <= '0;
      ex_st_val   <= '0;
      ex_dest     <= '0;
      ex_wb_en    <= 1'b0;
      ex_mem_r_en <= 1'b0;
      ex_mem_w_en <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      ex_alu_res  <= alu_res;
      ex_st_val   <= idex.val_rm;
      ex_dest     <= idex.dest;
      ex_wb_en    <= vld_pipe[0] & idex.wb_en;
      ex_mem_r_en <= vld_pipe[0] & idex.mem_r_en;
      ex_mem_w_en <= vld_pipe[0] & idex.mem_w_en;
      if (status_upd) status <= nzcv_next;
      if (kill) begin
        vld_pipe[0] <= 1'b0;
        idex        <= '0;
      end else begin
        vld_pipe[0] <= id_valid;
        idex        <= id_in;
      end
    end
  end

endmodule

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
- Execute-stage consumer of the ID-stage control word: exe_cmd, mem_r_en, mem_w_en, s, b, wb_en.
- Holds the ID/EX pipeline register, the ALU, the NZCV status register and the branch-target adder.
- Drives the EX/MEM pipeline register. Sits between the ID stage and the MEM stage and returns branch_taken/status upstream for flush and condition check.

Parameters:
- WIDTH, 32, datapath width (PC, operands, results).
- REG_AW, 4, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- flush_in  in  1  external flush (hazard/branch unit); ID/EX loads a bubble.
- stall_in  in  1  hazard stall; ID/EX loads a bubble, upstream holds.
- id_valid  in  1  ID stage presents a valid instruction.
- pc_in  in  WIDTH  PC+4 of the ID instruction.
- exe_cmd  in  4  ALU command.
- mem_r_en  in  1  load.
- mem_w_en  in  1  store.
- s  in  1  update status.
- b  in  1  branch.
- wb_en  in  1  register write-back.
- val_rn  in  WIDTH  first operand.
- val2  in  WIDTH  second operand (already shifted/immediate).
- val_rm  in  WIDTH  store data.
- dest  in  REG_AW  destination register.
- imm24  in  24  signed branch offset in words.
- branch_taken  out  1  combinational; valid branch in ID/EX.
- branch_addr  out  WIDTH  combinational branch target.
- status  out  4  NZCV register, bit3=N, bit2=Z, bit1=C, bit0=V.
- ex_valid  out  1  EX/MEM entry valid.
- ex_alu_res  out  WIDTH  ALU result or memory address.
- ex_st_val  out  WIDTH  store data.
- ex_dest  out  REG_AW  destination.
- ex_wb_en, ex_mem_r_en, ex_mem_w_en  out  1 each  control, forced 0 when ex_valid=0.

Behaviour:
- Reset: all ID/EX fields, all EX/MEM outputs and status are 0. branch_taken is 0 as a consequence.
- ID/EX load priority at each edge: rst > (flush_in | branch_taken | stall_in) -> bubble > load.
  - A bubble is valid=0 with every control bit 0; data fields are don't-care.
  - branch_taken self-flushes the shadow instruction.
- Load captures all inputs, with valid = id_valid.
- Latency: an instruction captured at edge N appears on ex_* after edge N+1. Throughput is 1 per cycle.
- exe_cmd encoding, with A=val_rn, B=val2:
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+C.
  - 0100 SUB: A-B.
  - 0101 SBC: A-B-(~C).
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, flags unchanged.
- Loads and stores issue exe_cmd 0010, so the address is val_rn+val2.
- Arithmetic is done at WIDTH+1 bits.
  - C = bit WIDTH of the sum for ADD/ADC; C = no-borrow (A>=B+borrow, unsigned) for SUB/SBC.
  - V = signed overflow.
  - N = result MSB.
  - Z = (result==0).
  - Logical ops and MOV/MVN update N and Z only; C and V are kept.
- C used by ADC/SBC is the current status register value, not a forwarded one.
- Status update: at the edge where the ID/EX entry is valid & s & !mem_r_en & !mem_w_en. Compare/test instructions (s=1, wb_en=0) update status but produce ex_wb_en=0.
- Branch: branch_taken = valid & b. branch_addr = pc + (sign_extend(imm24) << 2), truncated to WIDTH with wrap-around.
  - The branch entry itself moves to EX/MEM with wb/mem controls as decoded (normally 0).
- EX/MEM: on each edge, loads the ID/EX entry results unconditionally (no back-pressure), including bubbles. ex_valid follows the entry's valid bit.
- Simultaneous events:
  - A status update and a new ADC in the same edge: the ADC in the following cycle sees the updated C.
  - flush_in together with stall_in gives a bubble.
- Reset mid-stream: both registers and status are cleared at that edge. No partial commit.

Decomposition:
- Shared package arm_defs_pkg holds:
  - exe_cmd localparams (CMD_MOV=4'b0001 ... CMD_EOR=4'b1000).
  - Status bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- One sub-module alu_unit: combinational; inputs A, B, exe_cmd, cin; outputs result and nzcv_next.
- Pipeline registers and the status register stay in exe_stage_unit.

Test Plan:
1. Reset, then ADD: val_rn=5, val2=7, s=1 -> after 2 edges ex_alu_res=12, ex_valid=1; status=0000.
2. SUB with s=1, val_rn=3, val2=3 -> status=0110 (Z=1, C=1). A following ADC with 1+1 gives 3.
3. ADD with s=1, 0x7FFFFFFF+1 -> result 0x80000000, status=1001. MOV with s=1, val2=0 then gives status=0101 (C,V kept).
4. Branch: pc_in=0x100, imm24=0xFFFFFE, id_valid=1, b=1 -> next cycle branch_taken=1, branch_addr=0xF8; the instruction presented in that cycle leaves ex_valid=0.
5. stall_in=1 with id_valid=1 -> ex_valid=0 one cycle later and status unchanged. flush_in behaves identically.
6. STR (mem_w_en, s=1) then rst mid-stream -> no status change from the STR, ex_st_val=val_rm; after rst all outputs are 0.
